rx_fifo: RTL and testbench

RX_FIFO -- requirements
Module: rx_fifo

---
 rtl/uart_pkg.sv | 12 +
 rtl/rx_fifo.sv | 103 ++++++++++
 tb/tb_rx_fifo.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART-path definitions: default widths/depths and the receive-capture FSM states.
package uart_pkg;

  localparam int UART_DATA_W   = 8;
  localparam int RX_FIFO_DEPTH = 8;

  typedef enum logic {
    RX_IDLE     = 1'b0,
    RX_WAIT_LOW = 1'b1
  } rx_state_e;

endpackage

// File: rtl/rx_fifo.sv
// Receive FIFO between uart_receive and ctrl: captures each byte once per irq level, never backpressures,
// and flags a sticky overrun when a byte arrives with no room.
module rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = RX_FIFO_DEPTH,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          rx_uart_data,
  input  logic                       rx_uart_irq,
  input  logic                       rx_uart_frame_err,
  output logic                       rx_uart_finish,
  output logic [DATA_W-1:0]          rx_ctrl_data,
  output logic                       rx_ctrl_frame_err,
  output logic                       rx_ctrl_irq,
  input  logic                       rx_ctrl_pop,
  output logic                       rx_ctrl_overrun,
  input  logic                       rx_ctrl_overrun_clr,
  output logic [$clog2(DEPTH):0]     rx_ctrl_count,
  output rx_state_e                  dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Handshake: rx_uart_irq is a level held by the receiver until it sees the one-cycle
  // rx_uart_finish pulse; rx_ctrl_pop is a one-cycle request, ignored when empty.

  rx_state_e         r_state;
  rx_state_e         w_state_nxt;
  logic              w_capture;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overrun;
  logic              r_finish;
  logic [DATA_W:0]   r_mem [DEPTH];
  logic              w_pop;
  logic              w_full;
  logic              w_push_ok;

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (rx_uart_irq) begin
          w_capture   = 1'b1;
          w_state_nxt = RX_WAIT_LOW;
        end
      end
      RX_WAIT_LOW: begin
        if (!rx_uart_irq) w_state_nxt = RX_IDLE;
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  // A full FIFO can still take a byte if the head leaves on the same edge.
  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = rx_ctrl_pop && (r_count != '0);
  assign w_push_ok = w_capture && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RX_IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
      r_finish  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_finish <= w_capture;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Set takes priority over clear so a drop is never lost.
      if (w_capture && !w_push_ok) r_overrun <= 1'b1;
      else if (rx_ctrl_overrun_clr) r_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= {rx_uart_frame_err, rx_uart_data};
  end

  assign rx_uart_finish    = r_finish;
  assign rx_ctrl_data      = r_mem[r_rd_ptr][DATA_W-1:0];
  assign rx_ctrl_frame_err = r_mem[r_rd_ptr][DATA_W];
  assign rx_ctrl_irq       = (r_count != '0);
  assign rx_ctrl_overrun   = r_overrun;
  assign rx_ctrl_count     = r_count;
  assign dbg_state         = r_state;

endmodule

// File: tb/tb_rx_fifo.sv
// Bench for rx_fifo: queue-based reference model checked every cycle, directed scenarios with literal
// expectations, then randomized receiver/controller traffic.
module tb_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 8;
  localparam int DW    = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int W     = DW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] rx_uart_data = '0;
  logic          rx_uart_irq = 1'b0;
  logic          rx_uart_frame_err = 1'b0;
  logic          rx_ctrl_pop = 1'b0;
  logic          rx_ctrl_overrun_clr = 1'b0;
  logic          rx_uart_finish;
  logic [DW-1:0] rx_ctrl_data;
  logic          rx_ctrl_frame_err;
  logic          rx_ctrl_irq;
  logic          rx_ctrl_overrun;
  logic [CW-1:0] rx_ctrl_count;
  rx_state_e     dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int finish_cnt = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  rx_fifo #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .rx_uart_data        (rx_uart_data),
    .rx_uart_irq         (rx_uart_irq),
    .rx_uart_frame_err   (rx_uart_frame_err),
    .rx_uart_finish      (rx_uart_finish),
    .rx_ctrl_data        (rx_ctrl_data),
    .rx_ctrl_frame_err   (rx_ctrl_frame_err),
    .rx_ctrl_irq         (rx_ctrl_irq),
    .rx_ctrl_pop         (rx_ctrl_pop),
    .rx_ctrl_overrun     (rx_ctrl_overrun),
    .rx_ctrl_overrun_clr (rx_ctrl_overrun_clr),
    .rx_ctrl_count       (rx_ctrl_count),
    .dbg_state           (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];
  bit m_armed = 1'b1;
  bit m_ovr   = 1'b0;
  bit m_fin   = 1'b0;
  bit m_push, m_pop, m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_armed = 1'b1;
      m_ovr   = 1'b0;
      m_fin   = 1'b0;
    end else begin
      m_push = m_armed && rx_uart_irq;
      m_pop  = rx_ctrl_pop && (exp_q.size() > 0);
      m_acc  = m_push && ((exp_q.size() < DEPTH) || m_pop);
      if (m_pop) void'(exp_q.pop_front());
      if (m_acc) exp_q.push_back({rx_uart_frame_err, rx_uart_data});
      if (m_push && !m_acc) m_ovr = 1'b1;
      else if (rx_ctrl_overrun_clr) m_ovr = 1'b0;
      m_fin = m_push;
      if (m_push) m_armed = 1'b0;
      else if (!rx_uart_irq) m_armed = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("count", 32'(rx_ctrl_count), 32'(exp_q.size()));
    check("irq", 32'(rx_ctrl_irq), 32'(exp_q.size() != 0));
    check("overrun", 32'(rx_ctrl_overrun), 32'(m_ovr));
    check("finish", 32'(rx_uart_finish), 32'(m_fin));
    check("state", 32'(dbg_state), 32'(m_armed ? RX_IDLE : RX_WAIT_LOW));
    if (exp_q.size() > 0) begin
      check("head_data", 32'(rx_ctrl_data), 32'(exp_q[0][DW-1:0]));
      check("head_ferr", 32'(rx_ctrl_frame_err), 32'(exp_q[0][DW]));
    end
    if (rx_uart_finish) finish_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] d, input logic fe, input logic with_pop);
    bit got = 1'b0;
    @(posedge clk); #1;
    rx_uart_data = d; rx_uart_frame_err = fe; rx_uart_irq = 1'b1; rx_ctrl_pop = with_pop;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      rx_ctrl_pop = 1'b0;
      if (rx_uart_finish) got = 1'b1;
    end
    check("finish_seen", 32'(got), 32'd1);
    rx_uart_irq = 1'b0;
  endtask

  task automatic pop_one();
    @(posedge clk); #1; rx_ctrl_pop = 1'b1;
    @(posedge clk); #1; rx_ctrl_pop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fc0;
    bit rcv_done;
    logic [7:0] e;

    idle(3);
    check("rst_count", 32'(rx_ctrl_count), 32'd0);
    check("rst_irq", 32'(rx_ctrl_irq), 32'd0);
    check("rst_finish", 32'(rx_uart_finish), 32'd0);
    check("rst_overrun", 32'(rx_ctrl_overrun), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // single byte
    fc0 = finish_cnt;
    send_byte(8'hA5, 1'b0, 1'b0);
    check("single_count", 32'(rx_ctrl_count), 32'd1);
    check("single_data", 32'(rx_ctrl_data), 32'hA5);
    check("single_irq", 32'(rx_ctrl_irq), 32'd1);
    idle(3);
    check("single_finish_pulses", 32'(finish_cnt - fc0), 32'd1);
    pop_one();
    check("single_drained", 32'(rx_ctrl_count), 32'd0);

    // fill to the brim, then one too many
    for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0);
    idle(1);
    check("fill_count", 32'(rx_ctrl_count), 32'd8);
    check("fill_overrun", 32'(rx_ctrl_overrun), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      check("fill_order", 32'(rx_ctrl_data), 32'(i));
      pop_one();
    end
    check("fill_empty", 32'(rx_ctrl_count), 32'd0);
    check("overrun_sticky", 32'(rx_ctrl_overrun), 32'd1);
    rx_ctrl_overrun_clr = 1'b1; idle(1); rx_ctrl_overrun_clr = 1'b0;
    check("overrun_cleared", 32'(rx_ctrl_overrun), 32'd0);

    // full with push+pop on the same edge
    for (int i = 0; i < DEPTH; i++) send_byte(8'h10 + 8'(i), 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b1);
    check("pp_count", 32'(rx_ctrl_count), 32'd8);
    check("pp_no_overrun", 32'(rx_ctrl_overrun), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      e = (i < DEPTH - 1) ? 8'h11 + 8'(i) : 8'h55;
      check("pp_order", 32'(rx_ctrl_data), 32'(e));
      pop_one();
    end

    // overrun set and clear on the same edge: set wins
    for (int i = 0; i < DEPTH; i++) send_byte(8'h20 + 8'(i), 1'b0, 1'b0);
    @(posedge clk); #1;
    rx_ctrl_overrun_clr = 1'b1; rx_uart_data = 8'hEE; rx_uart_irq = 1'b1;
    @(posedge clk); #1;
    check("set_beats_clr", 32'(rx_ctrl_overrun), 32'd1);
    rx_uart_irq = 1'b0;
    idle(1);
    rx_ctrl_overrun_clr = 1'b0;
    check("clr_after", 32'(rx_ctrl_overrun), 32'd0);
    for (int i = 0; i < DEPTH; i++) pop_one();

    // frame error flag follows its own byte
    send_byte(8'h3C, 1'b1, 1'b0);
    send_byte(8'h42, 1'b0, 1'b0);
    check("ferr_head_data", 32'(rx_ctrl_data), 32'h3C);
    check("ferr_head_flag", 32'(rx_ctrl_frame_err), 32'd1);
    pop_one();
    check("clean_head_data", 32'(rx_ctrl_data), 32'h42);
    check("clean_head_flag", 32'(rx_ctrl_frame_err), 32'd0);
    pop_one();

    // irq held for 20 cycles: one capture only
    fc0 = finish_cnt;
    @(posedge clk); #1; rx_uart_data = 8'h77; rx_uart_irq = 1'b1;
    idle(20);
    rx_uart_irq = 1'b0;
    idle(2);
    check("held_finish_pulses", 32'(finish_cnt - fc0), 32'd1);
    check("held_count", 32'(rx_ctrl_count), 32'd1);
    pop_one();

    // asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) send_byte(8'h60 + 8'(i), 1'b0, 1'b0);
    check("pre_rst_count", 32'(rx_ctrl_count), 32'd3);
    @(posedge clk); #1; rst_n = 1'b0; #1;
    check("async_rst_count", 32'(rx_ctrl_count), 32'd0);
    check("async_rst_irq", 32'(rx_ctrl_irq), 32'd0);
    idle(2); rst_n = 1'b1;
    pop_one();
    check("empty_pop_count", 32'(rx_ctrl_count), 32'd0);

    // reset during a handshake, irq still high afterwards
    @(posedge clk); #1; rx_uart_data = 8'h9A; rx_uart_irq = 1'b1;
    @(posedge clk); #1;
    check("inflight_finish", 32'(rx_uart_finish), 32'd1);
    rst_n = 1'b0; #1;
    check("inflight_dropped", 32'(rx_ctrl_count), 32'd0);
    check("inflight_finish_rst", 32'(rx_uart_finish), 32'd0);
    idle(2); rst_n = 1'b1;
    @(posedge clk); #1;
    check("recapture_finish", 32'(rx_uart_finish), 32'd1);
    check("recapture_data", 32'(rx_ctrl_data), 32'h9A);
    rx_uart_irq = 1'b0;
    idle(3);
    check("recapture_once", 32'(rx_ctrl_count), 32'd1);
    pop_one();

    // randomized traffic
    rcv_done = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (rx_uart_finish) rcv_done = 1'b1;
      if (!rx_uart_irq) begin
        if ($urandom_range(99) < 35) begin
          rx_uart_data      = 8'($urandom);
          rx_uart_frame_err = 1'($urandom_range(1));
          rx_uart_irq       = 1'b1;
          rcv_done          = 1'b0;
        end
      end else if (rcv_done && $urandom_range(99) < 50) begin
        rx_uart_irq = 1'b0;
      end
      rx_ctrl_pop         = ($urandom_range(99) < ((cyc < 300) ? 10 : 50));
      rx_ctrl_overrun_clr = ($urandom_range(99) < 8);
    end
    @(negedge clk);
    rx_uart_irq = 1'b0; rx_ctrl_pop = 1'b0; rx_ctrl_overrun_clr = 1'b0;
    for (int i = 0; i < 2 * DEPTH && rx_ctrl_count != 0; i++) pop_one();
    idle(2);
    check("final_drained", 32'(rx_ctrl_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
